// File: rtl/sigmoid_alu_sequencer.sv
// rtl/sigmoid_alu_sequencer.sv - operand/control sequencer feeding one neuron through the sigmoid ALU
//
// Purpose:
//   Computes one neuron per accepted start. Reads G = NUM_INPUTS/4 packed weight/input
//   groups from two sync-read memories, registers them as ALU operands, strobes clear
//   and accumulate at the ALU pipeline timing, then captures the 5-bit sigmoid output
//   and holds it on a valid/ready result port.
//
// Ports:
//   clk, n_rst                  clock (posedge) and asynchronous active-low reset
//   start, bias_in              one-cycle request (IDLE only) and neuron bias to latch
//   busy                        high in every state except IDLE
//   w_ren/x_ren, w_addr/x_addr  memory read enable and group index (same on both)
//   w_rdata/x_rdata             packed nibbles, lane 1 in [3:0], 1-cycle read latency
//   weight1..4, input1..4, bias registered ALU operands
//   clear, accumulate           ALU accumulator controls
//   alu_out                     ALU sigmoid output
//   result, result_valid        captured neuron output, held until result_ready
//   result_ready                consumer acceptance
module sigmoid_alu_sequencer #(
   parameter int NUM_INPUTS = 8,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [3:0]        bias_in,
   output logic              busy,
   output logic              w_ren,
   output logic              x_ren,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] x_addr,
   input  logic [15:0]       w_rdata,
   input  logic [15:0]       x_rdata,
   output logic [3:0]        weight1,
   output logic [3:0]        weight2,
   output logic [3:0]        weight3,
   output logic [3:0]        weight4,
   output logic [3:0]        input1,
   output logic [3:0]        input2,
   output logic [3:0]        input3,
   output logic [3:0]        input4,
   output logic [3:0]        bias,
   output logic              clear,
   output logic              accumulate,
   input  logic [4:0]        alu_out,
   output logic [4:0]        result,
   output logic              result_valid,
   input  logic              result_ready
);

   localparam int                G        = NUM_INPUTS / 4;
   localparam logic [ADDR_W-1:0] LAST_GRP = ADDR_W'(G - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      CAPTURE,
      DONE
   } state_t;

   state_t              state_q;
   logic                busy_q;
   logic                ren_q;
   logic                clear_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [3:0]          bias_q;
   logic [4:0]          result_q;
   logic                result_valid_q;

   // vld_q[0]: read data valid, vld_q[1]: operand regs valid, vld_q[2]: accumulate strobe
   logic [2:0]          vld_q;
   logic [15:0]         wop_q;
   logic [15:0]         xop_q;
   logic [15:0]         wop_d;
   logic [15:0]         xop_d;

   // Control FSM; all outputs registered alongside the state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         ren_q          <= 1'b0;
         clear_q        <= 1'b0;
         addr_q         <= '0;
         bias_q         <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
                  bias_q  <= bias_in;
                  clear_q <= 1'b1;
                  ren_q   <= 1'b1;
                  addr_q  <= '0;
               end
            end
            // CLEAR issues group 0; STREAM issues the remaining groups. Both stop
            // once the last group address has been presented.
            CLEAR, STREAM: begin
               clear_q <= 1'b0;
               if (addr_q == LAST_GRP) begin
                  state_q <= DRAIN;
                  ren_q   <= 1'b0;
               end else begin
                  state_q <= STREAM;
                  addr_q  <= addr_q + 1'b1;
               end
            end
            // Wait until the final accumulate strobe is the only thing left in flight.
            DRAIN: begin
               if (vld_q[1:0] == 2'b00) begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               result_q       <= alu_out;
               result_valid_q <= 1'b1;
               state_q        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  busy_q         <= 1'b0;
                  state_q        <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Operands are zeroed whenever the read stage holds no fetched group, so the
   // ALU never sees stale memory data between groups or neurons.
   always_comb begin
      wop_d = vld_q[0] ? w_rdata : '0;
      xop_d = vld_q[0] ? x_rdata : '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         vld_q <= '0;
         wop_q <= '0;
         xop_q <= '0;
      end else begin
         vld_q <= {vld_q[1:0], ren_q};
         wop_q <= wop_d;
         xop_q <= xop_d;
      end
   end

   assign busy         = busy_q;
   assign w_ren        = ren_q;
   assign x_ren        = ren_q;
   assign w_addr       = addr_q;
   assign x_addr       = addr_q;
   assign weight1      = wop_q[3:0];
   assign weight2      = wop_q[7:4];
   assign weight3      = wop_q[11:8];
   assign weight4      = wop_q[15:12];
   assign input1       = xop_q[3:0];
   assign input2       = xop_q[7:4];
   assign input3       = xop_q[11:8];
   assign input4       = xop_q[15:12];
   assign bias         = bias_q;
   assign clear        = clear_q;
   assign accumulate   = vld_q[2];
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sigmoid_alu_sequencer.sv
// tb/tb_sigmoid_alu_sequencer.sv - bench for sigmoid_alu_sequencer (G=2 and G=1 instances)
module tb_sigmoid_alu_sequencer;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic          start_s[2];
    logic [3:0]    bias_in_s[2];
    logic          busy_s[2];
    logic          w_ren_s[2];
    logic          x_ren_s[2];
    logic [AW-1:0] w_addr_s[2];
    logic [AW-1:0] x_addr_s[2];
    logic [15:0]   w_rdata_s[2];
    logic [15:0]   x_rdata_s[2];
    logic [3:0]    w1_s[2], w2_s[2], w3_s[2], w4_s[2];
    logic [3:0]    x1_s[2], x2_s[2], x3_s[2], x4_s[2];
    logic [3:0]    bias_s[2];
    logic          clear_s[2];
    logic          acc_s[2];
    logic [4:0]    alu_out_s[2];
    logic [4:0]    result_s[2];
    logic          rv_s[2];
    logic          rr_s[2];

    logic [15:0]   wmem[2][4];
    logic [15:0]   xmem[2][4];
    int            prod_q[2];
    int            acc_q[2];

    int            n_pass = 0;
    int            n_chk  = 0;
    logic [4:0]    exp_q[$];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sigmoid_alu_sequencer #(
            .NUM_INPUTS (k == 0 ? 8 : 4),
            .ADDR_W     (AW)
        ) u_dut (
            .clk          (clk),
            .n_rst        (n_rst),
            .start        (start_s[k]),
            .bias_in      (bias_in_s[k]),
            .busy         (busy_s[k]),
            .w_ren        (w_ren_s[k]),
            .x_ren        (x_ren_s[k]),
            .w_addr       (w_addr_s[k]),
            .x_addr       (x_addr_s[k]),
            .w_rdata      (w_rdata_s[k]),
            .x_rdata      (x_rdata_s[k]),
            .weight1      (w1_s[k]),
            .weight2      (w2_s[k]),
            .weight3      (w3_s[k]),
            .weight4      (w4_s[k]),
            .input1       (x1_s[k]),
            .input2       (x2_s[k]),
            .input3       (x3_s[k]),
            .input4       (x4_s[k]),
            .bias         (bias_s[k]),
            .clear        (clear_s[k]),
            .accumulate   (acc_s[k]),
            .alu_out      (alu_out_s[k]),
            .result       (result_s[k]),
            .result_valid (rv_s[k]),
            .result_ready (rr_s[k])
        );
    end

    task automatic chk(input string tag, input bit ok);
        n_chk++;
        if (ok) n_pass++;
        else $error("FAIL %s", tag);
    endtask

    function automatic int mac(input logic [15:0] w, input logic [15:0] x);
        int s;
        logic signed [3:0] wn;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            wn = w[i*4 +: 4];
            s += int'(wn) * int'(x[i*4 +: 4]);
        end
        return s;
    endfunction

    function automatic logic [4:0] sig(input int s, input logic [3:0] b);
        logic signed [3:0] bs;
        int t;
        bs = b;
        t = ((s + int'(bs)) >>> 5) + 16;
        if (t < 0) t = 0;
        else if (t > 31) t = 31;
        return 5'(t);
    endfunction

    function automatic logic [4:0] expect_res(input int k, input int g, input logic [3:0] b);
        int s;
        s = 0;
        for (int i = 0; i < g; i++) s += mac(wmem[k][i], xmem[k][i]);
        return sig(s, b);
    endfunction

    function automatic logic [63:0] outs_vec(input int k);
        return {1'b0, busy_s[k], w_ren_s[k], x_ren_s[k], w_addr_s[k], x_addr_s[k],
                w4_s[k], w3_s[k], w2_s[k], w1_s[k], x4_s[k], x3_s[k], x2_s[k], x1_s[k],
                bias_s[k], clear_s[k], acc_s[k], result_s[k], rv_s[k]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            w_rdata_s[k] <= w_ren_s[k] ? wmem[k][w_addr_s[k][1:0]] : 16'hDEAD;
            x_rdata_s[k] <= x_ren_s[k] ? xmem[k][x_addr_s[k][1:0]] : 16'hBEEF;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            prod_q[k] <= mac({w4_s[k], w3_s[k], w2_s[k], w1_s[k]},
                             {x4_s[k], x3_s[k], x2_s[k], x1_s[k]});
            if (clear_s[k]) acc_q[k] <= 0;
            else if (acc_s[k]) acc_q[k] <= acc_q[k] + prod_q[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) alu_out_s[k] = sig(acc_q[k], bias_s[k]);
    end

    longint unsigned clr_m, acc_m, ren_m, busy_m;
    logic [AW-1:0]   addr_tr[64];
    int              vrise, vcnt, hs_cyc, unstable;
    logic            post_rv, post_busy;
    logic [4:0]      held, post_res;

    task automatic run(input int k, input logic [3:0] b, input int delay,
                       input bit pulses, input bit chk_ops);
        int g;
        bit done;
        logic [4:0] e;
        g = (k == 0) ? 2 : 1;
        exp_q.push_back(expect_res(k, g, b));
        clr_m = 0; acc_m = 0; ren_m = 0; busy_m = 0;
        vrise = -1; vcnt = 0; hs_cyc = -1; unstable = 0; done = 0; held = '0;
        for (int i = 0; i < 64; i++) addr_tr[i] = '1;
        start_s[k]   = 1'b1;
        bias_in_s[k] = b;
        rr_s[k]      = (delay < 0);
        for (int c = 1; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            start_s[k] = 1'b0;
            if (clear_s[k]) clr_m |= 64'd1 << c;
            if (acc_s[k])   acc_m |= 64'd1 << c;
            if (w_ren_s[k]) ren_m |= 64'd1 << c;
            if (busy_s[k])  busy_m |= 64'd1 << c;
            addr_tr[c] = w_addr_s[k];
            if (chk_ops && c == 1) chk("bias_latched", bias_s[k] === b);
            if (chk_ops && c >= 3 && c <= g + 2) begin
                chk("weights", {w4_s[k], w3_s[k], w2_s[k], w1_s[k]} === wmem[k][c-3]);
                chk("inputs", {x4_s[k], x3_s[k], x2_s[k], x1_s[k]} === xmem[k][c-3]);
            end
            if (chk_ops && c == g + 3)
                chk("ops_zero_after", {w4_s[k], w3_s[k], w2_s[k], w1_s[k],
                                       x4_s[k], x3_s[k], x2_s[k], x1_s[k]} === 32'h0);
            if (rv_s[k]) begin
                if (vrise < 0) begin
                    vrise = c;
                    held  = result_s[k];
                end
                vcnt++;
                if (result_s[k] !== held) unstable++;
            end
            if (pulses && (c == 2 || c == 5 || (vrise >= 0 && c == vrise + 1))) start_s[k] = 1'b1;
            rr_s[k] = (delay < 0) || (rv_s[k] && (c - vrise >= delay));
            if (rv_s[k] && rr_s[k]) begin
                hs_cyc = c;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bx;
                chk("result", result_s[k] === e);
                done = 1;
            end
        end
        chk("handshake_seen", hs_cyc >= 0);
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        rr_s[k]    = 1'b0;
        post_rv    = rv_s[k];
        post_busy  = busy_s[k];
        post_res   = result_s[k];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idle_busy;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; bias_in_s[k] = '0; rr_s[k] = 1'b0;
            for (int g = 0; g < 4; g++) begin
                wmem[k][g] = '0; xmem[k][g] = '0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_g2", outs_vec(0) === 64'h0);
        chk("reset_outs_g1", outs_vec(1) === 64'h0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        wmem[0][0] = 16'h12F3; xmem[0][0] = 16'h4A5C;
        wmem[0][1] = 16'h8E61; xmem[0][1] = 16'h3B07;
        run(0, 4'h3, 2, 0, 1);
        chk("t1_clear_mask", clr_m === 64'h2);
        chk("t1_acc_mask", acc_m === 64'h30);
        chk("t1_ren_mask", ren_m === 64'h6);
        chk("t1_addr_c1", addr_tr[1] === 8'd0);
        chk("t1_addr_c2", addr_tr[2] === 8'd1);
        chk("t1_valid_rise", vrise === 7);
        chk("t1_busy_mask", busy_m === (64'd1 << (hs_cyc + 1)) - 64'd2);
        chk("t1_post_valid", post_rv === 1'b0);
        chk("t1_post_busy", post_busy === 1'b0);

        wmem[0][0] = 16'h7777; xmem[0][0] = 16'hFFFF;
        wmem[0][1] = 16'h7777; xmem[0][1] = 16'hFFFF;
        run(0, 4'h0, 10, 0, 1);
        chk("t2_valid_cycles", vcnt === 11);
        chk("t2_unstable", unstable === 0);
        chk("t2_valid_rise", vrise === 7);

        wmem[0][0] = 16'($urandom); xmem[0][0] = 16'($urandom);
        wmem[0][1] = 16'($urandom); xmem[0][1] = 16'($urandom);
        run(0, 4'($urandom), 3, 1, 0);
        chk("t3_acc_mask", acc_m === 64'h30);
        chk("t3_clear_mask", clr_m === 64'h2);
        idle_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (busy_s[0] || rv_s[0] || clear_s[0]) idle_busy++;
        end
        chk("t3_no_second_run", idle_busy === 0);
        chk("t3_sb_empty", exp_q.size() === 0);
        run(0, 4'hA, 2, 0, 0);
        chk("t3_rerun_clear", clr_m === 64'h2);
        chk("t3_rerun_acc", acc_m === 64'h30);
        chk("t3_rerun_ren", ren_m === 64'h6);
        chk("t3_rerun_rise", vrise === 7);

        wmem[0][0] = 16'h0F21; xmem[0][0] = 16'h9182;
        wmem[0][1] = 16'hC3A4; xmem[0][1] = 16'h2E6D;
        run(0, 4'hE, -1, 0, 0);
        chk("t4_valid_cycles", vcnt === 1);
        chk("t4_valid_rise", vrise === 7);
        chk("t4_post_valid", post_rv === 1'b0);
        chk("t4_post_busy", post_busy === 1'b0);
        chk("t4_result_kept", post_res === held);

        wmem[0][0] = 16'h5B3D; xmem[0][0] = 16'h7C19;
        wmem[0][1] = 16'h96E2; xmem[0][1] = 16'hA4F0;
        start_s[0] = 1'b1; bias_in_s[0] = 4'h5;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start_s[0] = 1'b0;
        end
        chk("t5_acc_before_rst", acc_s[0] === 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("t5_async_outs", outs_vec(0) === 64'h0);
        @(posedge clk); #1;
        chk("t5_outs_held", outs_vec(0) === 64'h0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run(0, 4'h5, 1, 0, 1);
        chk("t5_clear_mask", clr_m === 64'h2);
        chk("t5_acc_mask", acc_m === 64'h30);
        chk("t5_valid_rise", vrise === 7);

        wmem[1][0] = 16'h4D7A; xmem[1][0] = 16'hE35B;
        run(1, 4'h2, 1, 0, 1);
        chk("t6_ren_mask", ren_m === 64'h2);
        chk("t6_addr_c1", addr_tr[1] === 8'd0);
        chk("t6_addr_c2", addr_tr[2] === 8'd0);
        chk("t6_acc_mask", acc_m === 64'h10);
        chk("t6_clear_mask", clr_m === 64'h2);
        chk("t6_valid_rise", vrise === 6);
        chk("t6_post_busy", post_busy === 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
